// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter helper for the fetch branch predictor
package bp_pkg;

    localparam int BP_ENTRIES = 64;
    localparam int BP_XLEN    = 32;
    localparam int BP_IDX     = $clog2(BP_ENTRIES);
    localparam int BP_TAG     = BP_XLEN - 2 - BP_IDX;

    typedef enum logic [1:0] {SNT, WNT, WT, ST} ctr_t;

    typedef enum logic {IDLE, CLEAR} bp_state_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG-1:0]   tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        else
            return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// rtl/bp_perf_counters.sv - free-running training and mispredict event counters
module bp_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        train_event,
    input  logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispred_count
);

    // Counters wrap naturally and are only ever cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (train_event) branch_count  <= branch_count + 32'd1;
            if (mispredict)  mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT+BTB fetch predictor with table clear; PERF_COUNTERS_EN adds event counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int XLEN    = BP_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    output logic            predictTakenF,
    output logic [XLEN-1:0] predictTargetF,
    input  logic            branchE,
    input  logic            jalE,
    input  logic            branchTakenE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            predTakenE,
    input  logic [XLEN-1:0] predTargetE,
    output logic            mispredictE,
    output logic [XLEN-1:0] redirectPCE,
    input  logic            clearReq,
    output logic            bpBusy,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredCount
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = XLEN - 2 - IDX;
    localparam logic [IDX-1:0] LAST = IDX'(ENTRIES - 1);

    btb_entry_t btb [ENTRIES];
    ctr_t       ctr [ENTRIES];

    bp_state_t      state;
    logic [IDX-1:0] ptr;

    logic [IDX-1:0] idx_f, idx_e;
    logic [TAG-1:0] tag_f, tag_e;
    logic           resolve_e, taken_e, train;
    logic           unused_pcf_lsbs;

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[XLEN-1:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[XLEN-1:IDX+2];
    assign unused_pcf_lsbs = ^PCF[1:0];

    // Lookup is purely combinational from the current table contents.
    assign predictTakenF  = (state == IDLE) && btb[idx_f].valid &&
                            (btb[idx_f].tag == tag_f) && ctr[idx_f][1];
    assign predictTargetF = btb[idx_f].target;

    assign resolve_e   = branchE | jalE;
    assign taken_e     = jalE | (branchE & branchTakenE);
    assign mispredictE = resolve_e &&
                         ((taken_e != predTakenE) || (taken_e && (predTargetE != PCTargetE)));
    assign redirectPCE = taken_e ? PCTargetE : PCE + XLEN'(4);

    // A clear request in the same cycle takes precedence over training.
    assign train  = (state == IDLE) && resolve_e && !clearReq;
    assign bpBusy = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clearReq) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '0;
                ctr[i] <= WNT;
            end
        end else if (state == CLEAR) begin
            btb[ptr].valid <= 1'b0;
            ctr[ptr]       <= WNT;
        end else if (train) begin
            ctr[idx_e] <= jalE ? ST : ctr_update(ctr[idx_e], branchTakenE);
            // Not-taken outcomes never allocate a BTB entry.
            if (taken_e)
                btb[idx_e] <= '{valid: 1'b1, tag: tag_e, target: PCTargetE};
        end
    end

`ifdef PERF_COUNTERS_EN
    bp_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .train_event   (resolve_e),
        .mispredict    (mispredictE),
        .branch_count  (branchCount),
        .mispred_count (mispredCount)
    );
`else
    assign branchCount  = 32'b0;
    assign mispredCount = 32'b0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, predictTargetF, PCE, PCTargetE, predTargetE, redirectPCE;
    logic        predictTakenF, branchE, jalE, branchTakenE, predTakenE;
    logic        mispredictE, clearReq, bpBusy;
    logic [31:0] branchCount, mispredCount;

    int checks = 0;
    int errors = 0;

`ifdef PERF_COUNTERS_EN
    localparam logic [31:0] EXP_BC = 32'd4;
    localparam logic [31:0] EXP_MC = 32'd1;
`else
    localparam logic [31:0] EXP_BC = 32'd0;
    localparam logic [31:0] EXP_MC = 32'd0;
`endif

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCF            (PCF),
        .predictTakenF  (predictTakenF),
        .predictTargetF (predictTargetF),
        .branchE        (branchE),
        .jalE           (jalE),
        .branchTakenE   (branchTakenE),
        .PCE            (PCE),
        .PCTargetE      (PCTargetE),
        .predTakenE     (predTakenE),
        .predTargetE    (predTargetE),
        .mispredictE    (mispredictE),
        .redirectPCE    (redirectPCE),
        .clearReq       (clearReq),
        .bpBusy         (bpBusy),
        .branchCount    (branchCount),
        .mispredCount   (mispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        br, jal, tk;
        logic [31:0] pce, tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_redir;
        logic        chk_perf;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic [31:0] pcf, input logic br, jal, tk,
                                input logic [31:0] pce, tgt, input logic ptk,
                                input logic [31:0] ptgt, input logic e_pt,
                                input logic [31:0] e_ptgt, input logic e_mis,
                                input logic [31:0] e_redir, input logic chk_perf);
        vec_t v;
        v.pcf = pcf; v.br = br; v.jal = jal; v.tk = tk; v.pce = pce; v.tgt = tgt;
        v.ptk = ptk; v.ptgt = ptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
        v.e_mis = e_mis; v.e_redir = e_redir; v.chk_perf = chk_perf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_e();
        branchE = 0; jalE = 0; branchTakenE = 0; PCE = 0; PCTargetE = 0;
        predTakenE = 0; predTargetE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train_jal(input logic [31:0] pc, input logic [31:0] tgt);
        jalE = 1; PCE = pc; PCTargetE = tgt; predTakenE = 0; predTargetE = 0;
        tick();
        idle_e();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = mk(32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,   0);
        tbl[1]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80,  0);
        tbl[2]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  0);
        tbl[3]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  0);
        tbl[4]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  0);
        tbl[5]  = mk(32'h100, 1, 0, 0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 1);
        tbl[6]  = mk(32'h100, 1, 0, 0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 0);
        tbl[7]  = mk(32'h100, 1, 0, 0, 32'h100, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h104, 0);
        tbl[8]  = mk(32'h100, 1, 0, 0, 32'h100, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h104, 0);
        tbl[9]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80,  0);
        tbl[10] = mk(32'h100, 1, 0, 1, 32'h100, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80,  0);
        tbl[11] = mk(32'h200, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,   0);
        tbl[12] = mk(32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,   0);
        tbl[13] = mk(32'h200, 0, 1, 0, 32'h200, 32'h400, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0);
        tbl[14] = mk(32'h200, 0, 1, 0, 32'h200, 32'h400, 1, 32'h3FC, 1, 32'h400, 1, 32'h400, 0);
        tbl[15] = mk(32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,   0);
        tbl[16] = mk(32'h200, 0, 1, 0, 32'h200, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h400, 0);

        rst_n = 0; clearReq = 0; PCF = 32'h100;
        idle_e();
        repeat (2) @(posedge clk);
        #1;
        check("reset_predict_taken", {31'b0, predictTakenF}, 32'd0);
        check("reset_predict_target", predictTargetF, 32'd0);
        check("reset_mispredict", {31'b0, mispredictE}, 32'd0);
        check("reset_busy", {31'b0, bpBusy}, 32'd0);
        check("reset_branch_count", branchCount, 32'd0);
        check("reset_mispred_count", mispredCount, 32'd0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 17; i++) begin
            PCF = tbl[i].pcf; branchE = tbl[i].br; jalE = tbl[i].jal;
            branchTakenE = tbl[i].tk; PCE = tbl[i].pce; PCTargetE = tbl[i].tgt;
            predTakenE = tbl[i].ptk; predTargetE = tbl[i].ptgt;
            #2;
            check($sformatf("vec%0d_predict_taken", i), {31'b0, predictTakenF}, {31'b0, tbl[i].e_pt});
            if (tbl[i].e_pt)
                check($sformatf("vec%0d_predict_target", i), predictTargetF, tbl[i].e_ptgt);
            check($sformatf("vec%0d_mispredict", i), {31'b0, mispredictE}, {31'b0, tbl[i].e_mis});
            check($sformatf("vec%0d_redirect", i), redirectPCE, tbl[i].e_redir);
            if (tbl[i].chk_perf) begin
                check("perf_branch_count", branchCount, EXP_BC);
                check("perf_mispred_count", mispredCount, EXP_MC);
            end
            tick();
        end
        idle_e();

        // Clear sequence: training dropped, lookups suppressed, clearReq re-pulse ignored.
        train_jal(32'h1FC, 32'h800);
        PCF = 32'h1FC; #1;
        check("pre_clear_hit", {31'b0, predictTakenF}, 32'd1);
        clearReq = 1;
        tick();
        clearReq = 0;
        n = 0;
        while (bpBusy && n < 200) begin
            n++;
            if (n == 1) begin
                PCF = 32'h1FC; #1;
                check("clear_no_predict", {31'b0, predictTakenF}, 32'd0);
            end
            if (n == 3) begin
                jalE = 1; PCE = 32'h204; PCTargetE = 32'h700; predTakenE = 0;
                #1;
                check("clear_mispredict", {31'b0, mispredictE}, 32'd1);
                check("clear_redirect", redirectPCE, 32'h700);
            end
            if (n == 20) clearReq = 1;
            tick();
            idle_e();
            clearReq = 0;
        end
        check("busy_cycles", n, 32'd64);
        PCF = 32'h1FC; #1;
        check("post_clear_miss_1fc", {31'b0, predictTakenF}, 32'd0);
        PCF = 32'h204; #1;
        check("post_clear_dropped_update", {31'b0, predictTakenF}, 32'd0);
        PCF = 32'h200; #1;
        check("post_clear_miss_200", {31'b0, predictTakenF}, 32'd0);
        tick();

        // Reset in the middle of a clear walk.
        train_jal(32'h1FC, 32'h800);
        PCF = 32'h1FC; #1;
        check("pre_reset_hit", {31'b0, predictTakenF}, 32'd1);
        clearReq = 1;
        tick();
        clearReq = 0;
        n = 0;
        while (n < 10) begin
            n++;
            tick();
        end
        check("mid_clear_busy", {31'b0, bpBusy}, 32'd1);
        rst_n = 0;
        #1;
        check("reset_mid_clear_busy", {31'b0, bpBusy}, 32'd0);
        check("reset_mid_clear_table", {31'b0, predictTakenF}, 32'd0);
        check("reset_mid_clear_branch_count", branchCount, 32'd0);
        check("reset_mid_clear_mispred_count", mispredCount, 32'd0);
        #5 rst_n = 1;
        tick();
        tick();
        check("after_reset_idle", {31'b0, bpBusy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
